// File: rtl/a2c_cbus_seq_pkg.sv
// Shared types and field positions for the AXI-to-CBUS sequencer.
// cw/dw/rd words are packed LSB-first; LEN/ID-dependent fields use helpers.
package a2c_pkg;

  localparam int CW_ADDR_L = 0;
  localparam int CW_ADDR_H = 31;
  localparam int CW_LEN_L  = 32;
  localparam int CW_PAD_W  = 3;

  function automatic int cw_len_h(int lb);
    return 31 + lb;
  endfunction
  function automatic int cw_burst_l(int lb);
    return 32 + lb;
  endfunction
  function automatic int cw_rnw(int lb);
    return 37 + lb;
  endfunction
  function automatic int cw_id_l(int lb);
    return 38 + lb;
  endfunction
  function automatic int cw_user(int lb, int idw);
    return 38 + lb + idw;
  endfunction

  localparam int DW_DATA_L = 0;
  localparam int DW_DATA_H = 31;
  localparam int DW_STRB_L = 32;
  localparam int DW_STRB_H = 35;
  localparam int DW_WLAST  = 36;

  localparam int RD_DATA_L = 0;
  localparam int RD_DATA_H = 31;
  localparam int RD_RESP_L = 32;
  localparam int RD_RESP_H = 33;
  localparam int RD_RLAST  = 34;
  localparam int RD_ID_L   = 35;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDAT,
    S_WREQ,
    S_RREQ,
    S_RPUSH,
    S_NEXT
  } state_e;

endpackage

// File: rtl/a2c_cbus_seq_if.sv
// Single-beat CBUS port: one outstanding request, held until ack.
interface a2c_cbus_if;
  logic        cbus_req;
  logic        cbus_rnw;
  logic [31:0] cbus_addr;
  logic [31:0] cbus_wdata;
  logic [3:0]  cbus_be;
  logic        cbus_ack;
  logic [31:0] cbus_rdata;
  logic        cbus_err;

  modport master (
    output cbus_req, cbus_rnw, cbus_addr,
    output cbus_wdata, cbus_be,
    input  cbus_ack, cbus_rdata, cbus_err
  );

  modport slave (
    input  cbus_req, cbus_rnw, cbus_addr,
    input  cbus_wdata, cbus_be,
    output cbus_ack, cbus_rdata, cbus_err
  );
endinterface

// File: rtl/a2c_cbus_seq_addr_gen.sv
// Next beat address for a 4-byte beat under FIXED/INCR/WRAP bursts.
// addr[1:0] survives because the wrap mask always covers the low two bits.
module a2c_addr_gen
  import a2c_pkg::*;
#(
  parameter int LEN_BITS = 8
) (
  input  logic [31:0]         addr_i,
  input  logic [LEN_BITS-1:0] len_i,
  input  logic [1:0]          burst_i,
  output logic [31:0]         addr_o
);
  logic [31:0] inc;
  logic [31:0] mask;

  assign inc  = addr_i + 32'd4;
  assign mask = (32'(len_i) << 2) | 32'd3;

  always_comb begin
    unique case (burst_i)
      BURST_FIXED: addr_o = addr_i;
      BURST_WRAP:  addr_o = (addr_i & ~mask) | (inc & mask);
      default:     addr_o = inc;
    endcase
  end
endmodule

// File: rtl/a2c_cbus_seq.sv
// Drains queued AXI bursts into single-beat CBUS accesses and
// returns read beats to the rd FIFO.
module a2c_cbus_seq
  import a2c_pkg::*;
#(
  parameter int LEN_BITS = 8,
  parameter int ID_DW = 4,
  parameter int TO_CYC = 255,
  localparam int CWFIFO_DW = 39 + LEN_BITS + ID_DW,
  localparam int DWFIFO_DW = 37,
  localparam int RDFIFO_DW = 36 + ID_DW
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [CWFIFO_DW-1:0] cwfifo_dataout,
  input  logic                 cwfifo_empty,
  output logic                 cwfifo_rd_op,
  input  logic [DWFIFO_DW-1:0] dwfifo_dataout,
  input  logic                 dwfifo_empty,
  output logic                 dwfifo_rd_op,
  output logic [RDFIFO_DW-1:0] rdfifo_datain,
  output logic                 rdfifo_wr_op,
  input  logic                 rdfifo_full,
  a2c_cbus_if.master           cbus,
  output logic                 busy,
  output logic [2:0]           err_sticky,
  input  logic                 err_clr
);
  localparam int TW  = $clog2(TO_CYC + 1);
  localparam int LH  = cw_len_h(LEN_BITS);
  localparam int BL  = cw_burst_l(LEN_BITS);
  localparam int RNW = cw_rnw(LEN_BITS);
  localparam int IDL = cw_id_l(LEN_BITS);
  localparam int USR = cw_user(LEN_BITS, ID_DW);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d, addr_nx;
  logic [LEN_BITS-1:0] len_q, len_d, beat_q, beat_d;
  logic [1:0]          burst_q, burst_d, resp_q, resp_d;
  logic                rnw_q, rnw_d, user_q, user_d;
  logic [ID_DW-1:0]    id_q, id_d;
  logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]          be_q, be_d;
  logic                rlast_q, rlast_d, req_q, req_d;
  logic [TW-1:0]       to_q, to_d;
  logic [2:0]          err_q, err_d, err_set;
  logic                cw_pop, dw_pop, rd_push;
  logic                last, tmo, wlast;
  logic [CW_PAD_W-1:0] unused_pad;

  assign unused_pad = cwfifo_dataout[RNW-1:RNW-CW_PAD_W];
  assign last  = (beat_q == len_q);
  assign wlast = dwfifo_dataout[DW_WLAST];
  assign tmo   = req_q && (to_q == TO_LAST) && !cbus.cbus_ack;

  a2c_addr_gen #(.LEN_BITS(LEN_BITS)) u_addr_gen (
    .addr_i  (addr_q),
    .len_i   (len_q),
    .burst_i (burst_q),
    .addr_o  (addr_nx)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    rnw_d   = rnw_q;
    id_d    = id_q;
    user_d  = user_q;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    rlast_d = rlast_q;
    err_set = 3'b000;
    cw_pop  = 1'b0;
    dw_pop  = 1'b0;
    rd_push = 1'b0;
    unique case (state_q)
      S_IDLE: if (!cwfifo_empty) begin
        cw_pop  = 1'b1;
        addr_d  = cwfifo_dataout[CW_ADDR_H:CW_ADDR_L];
        len_d   = cwfifo_dataout[LH:CW_LEN_L];
        burst_d = cwfifo_dataout[BL+1:BL];
        rnw_d   = cwfifo_dataout[RNW];
        id_d    = cwfifo_dataout[USR-1:IDL];
        user_d  = cwfifo_dataout[USR];
        beat_d  = '0;
        state_d = S_CMD;
      end
      S_CMD: begin
        state_d = rnw_q ? S_RREQ : S_WDAT;
        if (rnw_q) be_d = 4'hF;
      end
      S_WDAT: if (!dwfifo_empty) begin
        dw_pop     = 1'b1;
        wdata_d    = dwfifo_dataout[DW_DATA_H:DW_DATA_L];
        be_d       = dwfifo_dataout[DW_STRB_H:DW_STRB_L];
        err_set[0] = (wlast != last);
        state_d    = S_WREQ;
      end
      S_WREQ: if (cbus.cbus_ack || tmo) begin
        err_set[1] = cbus.cbus_ack && cbus.cbus_err;
        err_set[2] = tmo;
        state_d    = S_NEXT;
      end
      S_RREQ: if (cbus.cbus_ack || tmo) begin
        err_set[2] = tmo;
        rdata_d    = tmo ? 32'h0 : cbus.cbus_rdata;
        resp_d     = (tmo || cbus.cbus_err) ? RESP_SLVERR : RESP_OKAY;
        rlast_d    = last;
        state_d    = S_RPUSH;
      end
      S_RPUSH: if (!rdfifo_full) begin
        rd_push = 1'b1;
        state_d = S_NEXT;
      end
      S_NEXT: if (last) begin
        state_d = S_IDLE;
      end else begin
        beat_d  = beat_q + 1'b1;
        addr_d  = addr_nx;
        state_d = rnw_q ? S_RREQ : S_WDAT;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_WREQ) || (state_d == S_RREQ);
    to_d  = req_q ? to_q + 1'b1 : '0;
    err_d = (err_q | err_set) & ~{3{err_clr}};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      rnw_q   <= 1'b0;
      id_q    <= '0;
      user_q  <= 1'b0;
      beat_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      rlast_q <= 1'b0;
      req_q   <= 1'b0;
      to_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      rnw_q   <= rnw_d;
      id_q    <= id_d;
      user_q  <= user_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      rlast_q <= rlast_d;
      req_q   <= req_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // FIFO strobes are combinational, so mask them in the reset cycle
  assign cwfifo_rd_op  = cw_pop & ~areset;
  assign dwfifo_rd_op  = dw_pop & ~areset;
  assign rdfifo_wr_op  = rd_push & ~areset;
  assign rdfifo_datain = {user_q, id_q, rlast_q, resp_q, rdata_q};

  assign cbus.cbus_req   = req_q;
  assign cbus.cbus_rnw   = rnw_q;
  assign cbus.cbus_addr  = addr_q;
  assign cbus.cbus_wdata = wdata_q;
  assign cbus.cbus_be    = be_q;

  assign busy       = (state_q != S_IDLE);
  assign err_sticky = err_q;
endmodule
